// File: rtl/doc_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : doc_uart_pkg                                                  |
// | Description: Shared state encoding, character constants and byte helpers   |
// |              for the document UART streamer.                               |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package doc_uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SCAN    = 3'd1,
      ST_FETCH   = 3'd2,
      ST_FRAME   = 3'd3,
      ST_EOL     = 3'd4,
      ST_NEXTROW = 3'd5,
      ST_DONE    = 3'd6
   } state_t;

   localparam logic [7:0] CHR_SPACE = 8'h20;
   localparam logic [7:0] CHR_QMARK = 8'h3F;
   localparam logic [7:0] CHR_CR    = 8'h0D;
   localparam logic [7:0] CHR_LF    = 8'h0A;

   // NUL renders as a space; anything else outside printable ASCII becomes '?'.
   function automatic logic [7:0] sanitize(input logic [7:0] b);
      logic [7:0] r;
      if (b == 8'h00) begin
         r = CHR_SPACE;
      end else if ((b < 8'h20) || (b > 8'h7E)) begin
         r = CHR_QMARK;
      end else begin
         r = b;
      end
      return r;
   endfunction

   // Blank cells are the ones trimmed from the end of a row.
   function automatic logic is_blank(input logic [7:0] b);
      return (b == 8'h00) || (b == CHR_SPACE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : uart_tx_frame                                                 |
// | Description: 8N1 frame serialiser. Each bit is held DIV clocks. ready is   |
// |              also raised during the final stop-bit clock so a new frame    |
// |              can follow back to back.                                      |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module uart_tx_frame #(
   parameter int DIV = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       ready
);

   localparam int              CNT_W     = $clog2(DIV);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

   logic             active_q, active_d;
   logic [CNT_W-1:0] baud_q,   baud_d;
   logic [3:0]       bit_q,    bit_d;
   logic [9:0]       shift_q,  shift_d;
   logic             last_tick;

   // Baud/bit counting and frame shift register next-state.
   always_comb begin
      active_d  = active_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      last_tick = active_q && (baud_q == BAUD_LAST) && (bit_q == 4'd9);
      ready     = !active_q || last_tick;
      tx        = active_q ? shift_q[0] : 1'b1;

      if (start && ready) begin
         active_d = 1'b1;
         baud_d   = '0;
         bit_d    = 4'd0;
         shift_d  = {1'b1, data, 1'b0};
      end else if (active_q) begin
         if (baud_q == BAUD_LAST) begin
            baud_d = '0;
            if (bit_q == 4'd9) begin
               active_d = 1'b0;
            end else begin
               bit_d   = bit_q + 4'd1;
               shift_d = {1'b1, shift_q[9:1]};
            end
         end else begin
            baud_d = baud_q + 1'b1;
         end
      end
   end

   // Frame state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         active_q <= 1'b0;
         baud_q   <= '0;
         bit_q    <= 4'd0;
         shift_q  <= '1;
      end else begin
         active_q <= active_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/doc_uart_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : doc_uart_streamer                                             |
// | Description: Walks the document RAM row by row and sends it over 8N1 UART, |
// |              with trailing-blank trimming, configurable end-of-line,       |
// |              non-printable substitution and graceful abort.                |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module doc_uart_streamer #(
   parameter int CLK_HZ   = 100000000,
   parameter int BAUD     = 9600,
   parameter int COLS     = 20,
   parameter int ROWS     = 15,
   parameter int COL_W    = 5,
   parameter int ADDR_W   = 9,
   parameter int TRIM     = 1,
   parameter int EOL_MODE = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              send,
   input  logic              abort,
   output logic              read_en,
   output logic [ADDR_W-1:0] read_addr,
   input  logic [7:0]        read_data,
   output logic              busy,
   output logic              done,
   output logic              tx
);

   import doc_uart_pkg::*;

   localparam int               DIV       = CLK_HZ / BAUD;
   localparam int               ROW_W     = ADDR_W - COL_W;
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
   localparam logic             EOL_LAST  = (EOL_MODE == 2);
   // Where a row goes once its visible bytes are out (or it was found empty).
   localparam state_t           AFTER_ROW = (EOL_MODE == 0) ? ST_NEXTROW : ST_EOL;

   state_t           state_q,  state_d;
   logic [ROW_W-1:0] row_q,    row_d;
   logic [COL_W-1:0] col_q,    col_d;
   logic [COL_W-1:0] last_q,   last_d;
   logic             eol_q,    eol_d;
   logic             in_eol_q, in_eol_d;
   logic             abort_q,  abort_d;

   logic             abort_now;
   logic             tx_start;
   logic [7:0]       tx_data;
   logic             tx_ready;

   uart_tx_frame #(
      .DIV   (DIV)
   ) u_frame (
      .clk   (clk),
      .rst   (rst),
      .start (tx_start),
      .data  (tx_data),
      .tx    (tx),
      .ready (tx_ready)
   );

   assign read_addr = {row_q, col_q};
   assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done      = (state_q == ST_DONE);

   // Row/column walk, trimming scan, EOL emission and abort handling.
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      last_d    = last_q;
      eol_d     = eol_q;
      in_eol_d  = in_eol_q;
      abort_d   = abort_q;
      read_en   = 1'b0;
      tx_start  = 1'b0;
      tx_data   = 8'h00;
      abort_now = abort || abort_q;

      if (abort && busy) begin
         abort_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            abort_d = 1'b0;
            // A simultaneous abort cancels the request outright.
            if (send && !abort) begin
               row_d    = '0;
               eol_d    = 1'b0;
               in_eol_d = 1'b0;
               if (TRIM != 0) begin
                  col_d   = COL_LAST;
                  state_d = ST_SCAN;
               end else begin
                  col_d   = '0;
                  last_d  = COL_LAST;
                  state_d = ST_FETCH;
               end
            end
         end

         ST_SCAN: begin
            read_en = 1'b1;
            if (abort_now) begin
               state_d = ST_DONE;
            end else if (!is_blank(read_data)) begin
               last_d  = col_q;
               col_d   = '0;
               state_d = ST_FETCH;
            end else if (col_q == '0) begin
               // Whole row blank: nothing to fetch, but the EOL still goes out.
               state_d = AFTER_ROW;
            end else begin
               col_d = col_q - 1'b1;
            end
         end

         ST_FETCH: begin
            read_en = 1'b1;
            if (abort_now) begin
               state_d = ST_DONE;
            end else if (tx_ready) begin
               tx_start = 1'b1;
               tx_data  = sanitize(read_data);
               in_eol_d = 1'b0;
               state_d  = ST_FRAME;
            end
         end

         ST_EOL: begin
            if (abort_now) begin
               state_d = ST_DONE;
            end else if (tx_ready) begin
               tx_start = 1'b1;
               tx_data  = ((EOL_MODE == 2) && !eol_q) ? CHR_CR : CHR_LF;
               in_eol_d = 1'b1;
               state_d  = ST_FRAME;
            end
         end

         ST_FRAME: begin
            // tx_ready rises in the last stop-bit clock, so frames are never cut.
            if (tx_ready) begin
               if (abort_now) begin
                  state_d = ST_DONE;
               end else if (in_eol_q) begin
                  if (eol_q == EOL_LAST) begin
                     state_d = ST_NEXTROW;
                  end else begin
                     eol_d   = 1'b1;
                     state_d = ST_EOL;
                  end
               end else if (col_q < last_q) begin
                  col_d   = col_q + 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = AFTER_ROW;
               end
            end
         end

         ST_NEXTROW: begin
            eol_d = 1'b0;
            if (abort_now || (row_q == ROW_LAST)) begin
               state_d = ST_DONE;
            end else begin
               row_d = row_q + 1'b1;
               if (TRIM != 0) begin
                  col_d   = COL_LAST;
                  state_d = ST_SCAN;
               end else begin
                  col_d   = '0;
                  last_d  = COL_LAST;
                  state_d = ST_FETCH;
               end
            end
         end

         ST_DONE: begin
            abort_d = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Streamer state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         row_q    <= '0;
         col_q    <= '0;
         last_q   <= '0;
         eol_q    <= 1'b0;
         in_eol_q <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         col_q    <= col_d;
         last_q   <= last_d;
         eol_q    <= eol_d;
         in_eol_q <= in_eol_d;
         abort_q  <= abort_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_doc_uart_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_doc_uart_streamer                                          |
// | Description: Self-checking bench. Instance A: TRIM=1, CR LF endings.       |
// |              Instance B: TRIM=0, no endings. DIV=16, 4x2 document.         |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_doc_uart_streamer;

   localparam int DIV = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       send_a, abort_a, send_b, abort_b;
   logic       re_a, re_b, busy_a, busy_b, done_a, done_b, tx_a, tx_b;
   logic [2:0] ra_a, ra_b;
   logic [7:0] rd_a, rd_b;
   logic [7:0] mem_a [8];
   logic [7:0] mem_b [8];

   assign rd_a = mem_a[ra_a];
   assign rd_b = mem_b[ra_b];

   doc_uart_streamer #(
      .CLK_HZ(16), .BAUD(1), .COLS(4), .ROWS(2), .COL_W(2), .ADDR_W(3), .TRIM(1), .EOL_MODE(2)
   ) dut_a (
      .clk(clk), .rst(rst), .send(send_a), .abort(abort_a), .read_en(re_a), .read_addr(ra_a),
      .read_data(rd_a), .busy(busy_a), .done(done_a), .tx(tx_a)
   );

   doc_uart_streamer #(
      .CLK_HZ(16), .BAUD(1), .COLS(4), .ROWS(2), .COL_W(2), .ADDR_W(3), .TRIM(0), .EOL_MODE(0)
   ) dut_b (
      .clk(clk), .rst(rst), .send(send_b), .abort(abort_b), .read_en(re_b), .read_addr(ra_b),
      .read_data(rd_b), .busy(busy_b), .done(done_b), .tx(tx_b)
   );

   logic [1:0] tx_v, busy_v, done_v, re_v;
   assign tx_v   = {tx_b, tx_a};
   assign busy_v = {busy_b, busy_a};
   assign done_v = {done_b, done_a};
   assign re_v   = {re_b, re_a};

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   // Line monitors: UART decoding and protocol observations per instance.
   int         k [2];
   bit         inf [2];
   bit         busy_prev [2];
   logic [7:0] sh [2];
   int         starts [2];
   int         fs [2];
   int         done_cnt [2];
   int         done_cyc [2];
   int         busy_cyc [2];
   int         ferr [2];
   int         re_viol [2];
   int         busy_viol [2];
   logic [7:0] got_a [$];
   logic [7:0] got_b [$];
   logic [2:0] addr_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst) begin
            inf[d]       = 1'b0;
            busy_prev[d] = 1'b0;
         end else begin
            if (done_v[d]) begin
               done_cnt[d]++;
               done_cyc[d] = cyc;
            end
            if (busy_v[d]) busy_cyc[d]++;
            if (busy_prev[d] && !busy_v[d] && !done_v[d]) busy_viol[d]++;
            busy_prev[d] = busy_v[d];
            if (re_v[d] && (inf[d] || !tx_v[d])) re_viol[d]++;
            if (d == 0 && re_a) addr_q.push_back(ra_a);
            if (!inf[d]) begin
               if (!tx_v[d]) begin
                  inf[d] = 1'b1;
                  k[d]   = 0;
                  fs[d]  = cyc;
                  starts[d]++;
               end
            end else begin
               k[d]++;
               if ((k[d] == DIV/2 || k[d] == DIV-1) && tx_v[d]) ferr[d]++;
               if (k[d] >= DIV + DIV/2 && k[d] <= 8*DIV + DIV/2 && ((k[d] - DIV/2) % DIV) == 0)
                  sh[d] = {tx_v[d], sh[d][7:1]};
               if (k[d] == 9*DIV + DIV/2) begin
                  if (!tx_v[d]) ferr[d]++;
                  if (d == 0) got_a.push_back(sh[d]);
                  else        got_b.push_back(sh[d]);
                  inf[d] = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #(10 * 200000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference model: builds the expected byte stream from the document.
   logic [7:0] doc [8];
   logic [7:0] exp_q [$];

   function automatic logic [7:0] ref_sub(input logic [7:0] b);
      if (b == 8'h00) return 8'h20;
      if (b < 8'h20 || b > 8'h7E) return 8'h3F;
      return b;
   endfunction

   task automatic model(input int d);
      int last;
      exp_q.delete();
      for (int r = 0; r < 2; r++) begin
         last = -1;
         for (int c = 3; c >= 0; c--)
            if (last < 0 && (d == 1 || (doc[r*4+c] != 8'h00 && doc[r*4+c] != 8'h20))) last = c;
         for (int c = 0; c <= last; c++) exp_q.push_back(ref_sub(doc[r*4+c]));
         if (d == 0) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
         end
      end
   endtask

   function automatic logic [7:0] rnd_byte();
      int p = $urandom_range(0, 9);
      if (p < 3) return ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h20;
      if (p < 8) return 8'($urandom_range(8'h21, 8'h7E));
      return 8'($urandom_range(0, 255));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual %0h, required %0h", name, act, req);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_send(input int d);
      if (d == 0) send_a = 1'b1; else send_b = 1'b1;
      tick();
      send_a = 1'b0;
      send_b = 1'b0;
   endtask

   task automatic load_doc(input int d);
      for (int i = 0; i < 8; i++)
         if (d == 0) mem_a[i] = doc[i]; else mem_b[i] = doc[i];
      got_a.delete();
      got_b.delete();
      addr_q.delete();
   endtask

   task automatic wait_done(input int d, input int base, input string tag);
      int n = 0;
      while (done_cnt[d] == base && n < 6000) begin
         tick();
         n++;
      end
      chk({tag, " finished"}, 32'(n < 6000), 1);
   endtask

   task automatic wait_start(input int d, input int base, input string tag);
      int n = 0;
      while (starts[d] == base && n < 500) begin
         tick();
         n++;
      end
      chk({tag, " frame started"}, 32'(n < 500), 1);
   endtask

   task automatic cmp_stream(input int d, input string tag);
      int n_got;
      n_got = (d == 0) ? got_a.size() : got_b.size();
      chk({tag, " byte count"}, n_got, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < n_got; i++)
         chk($sformatf("%s byte%0d", tag, i), (d == 0) ? got_a[i] : got_b[i], exp_q[i]);
   endtask

   task automatic run_doc(input int d, input string tag);
      int base;
      load_doc(d);
      base = done_cnt[d];
      pulse_send(d);
      chk({tag, " busy after send"}, 32'(busy_v[d]), 1);
      wait_done(d, base, tag);
      repeat (4) tick();
      chk({tag, " done pulses"}, done_cnt[d] - base, 1);
   endtask

   // Vector table: document image (address order) and expected byte stream (send order).
   typedef struct packed {
      logic        cfg;
      logic [63:0] mem;
      logic [3:0]  n;
      logic [95:0] exp;
   } vec_t;

   vec_t       vecs [6];
   logic [2:0] exp_addr [9];

   initial begin
      int base, fs0, dc, n, st0;
      string tag;

      vecs[0] = '{cfg: 1'b0, mem: 64'h41422020_20202020, n: 4'd6,  exp: 96'h41420D0A0D0A_000000000000};
      vecs[1] = '{cfg: 1'b1, mem: 64'h00077A7F_4869217E, n: 4'd8,  exp: 96'h203F7A3F4869217E_00000000};
      vecs[2] = '{cfg: 1'b0, mem: 64'h20612062_0000FF00, n: 4'd11, exp: 96'h20612062_0D0A2020_3F0D0A00};
      vecs[3] = '{cfg: 1'b0, mem: 64'h00000000_00000000, n: 4'd4,  exp: 96'h0D0A0D0A_0000000000000000};
      vecs[4] = '{cfg: 1'b1, mem: 64'h20202020_20202020, n: 4'd8,  exp: 96'h2020202020202020_00000000};
      vecs[5] = '{cfg: 1'b0, mem: 64'h20202078_7E801F20, n: 4'd11, exp: 96'h20202078_0D0A7E3F_3F0D0A00};
      exp_addr = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd7, 3'd6, 3'd5, 3'd4};

      rst = 1'b0;
      send_a = 1'b0; abort_a = 1'b0; send_b = 1'b0; abort_b = 1'b0;
      for (int i = 0; i < 8; i++) begin
         mem_a[i] = 8'h20;
         mem_b[i] = 8'h20;
      end
      repeat (3) tick();
      chk("reset tx_a", 32'(tx_a), 1);
      chk("reset tx_b", 32'(tx_b), 1);
      chk("reset busy", 32'(busy_a), 0);
      chk("reset done", 32'(done_a), 0);
      chk("reset read_en", 32'(re_a), 0);
      chk("reset read_addr", 32'(ra_a), 0);
      rst = 1'b1;
      repeat (2) tick();

      // Table-driven documents.
      for (int v = 0; v < 6; v++) begin
         tag = $sformatf("vec%0d", v);
         for (int i = 0; i < 8; i++) doc[i] = vecs[v].mem[63-8*i -: 8];
         run_doc(int'(vecs[v].cfg), tag);
         exp_q.delete();
         for (int b = 0; b < int'(vecs[v].n); b++) exp_q.push_back(vecs[v].exp[95-8*b -: 8]);
         cmp_stream(int'(vecs[v].cfg), tag);
         if (v == 0) begin
            chk("vec0 addr count", addr_q.size(), 9);
            for (int i = 0; i < 9 && i < addr_q.size(); i++)
               chk($sformatf("vec0 addr%0d", i), 32'(addr_q[i]), 32'(exp_addr[i]));
         end
      end

      // Randomised documents against the reference model.
      for (int r = 0; r < 8; r++) begin
         for (int d = 0; d < 2; d++) begin
            tag = $sformatf("rnd%0d/%0d", r, d);
            for (int i = 0; i < 8; i++) doc[i] = rnd_byte();
            run_doc(d, tag);
            model(d);
            cmp_stream(d, tag);
         end
      end

      // Abort in the middle of the first frame.
      doc = '{8'h41, 8'h42, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
      load_doc(0);
      base = done_cnt[0];
      st0 = starts[0];
      pulse_send(0);
      wait_start(0, st0, "abort");
      fs0 = fs[0];
      n = 0;
      while (cyc < fs0 + 50 && n < 500) begin
         tick();
         n++;
      end
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      wait_done(0, base, "abort");
      dc = done_cyc[0] - fs0;
      chk("abort done clock in 158..162", 32'(dc >= 158 && dc <= 162), 1);
      repeat (400) tick();
      chk("abort frames", starts[0] - st0, 1);
      chk("abort byte count", got_a.size(), 1);
      chk("abort byte", (got_a.size() > 0) ? 32'(got_a[0]) : 32'hFFFF, 32'h41);
      chk("abort done pulses", done_cnt[0] - base, 1);
      chk("abort tx idle", 32'(tx_a), 1);

      // Reset during data bit d3, then a clean restart.
      doc = '{8'h48, 8'h69, 8'h20, 8'h00, 8'h59, 8'h6F, 8'h21, 8'h78};
      load_doc(0);
      st0 = starts[0];
      pulse_send(0);
      wait_start(0, st0, "reset");
      fs0 = fs[0];
      n = 0;
      while (cyc < fs0 + 70 && n < 500) begin
         tick();
         n++;
      end
      rst = 1'b0;
      tick();
      chk("mid-frame reset tx", 32'(tx_a), 1);
      chk("mid-frame reset busy", 32'(busy_a), 0);
      chk("mid-frame reset read_en", 32'(re_a), 0);
      rst = 1'b1;
      tick();
      run_doc(0, "restart");
      model(0);
      cmp_stream(0, "restart");
      chk("restart first addr", (addr_q.size() > 0) ? 32'(addr_q[0]) : 32'hFFFF, 3);

      // Send while busy is ignored.
      doc = '{8'h31, 8'h32, 8'h33, 8'h20, 8'h34, 8'h00, 8'h00, 8'h00};
      load_doc(0);
      base = done_cnt[0];
      st0 = starts[0];
      pulse_send(0);
      wait_start(0, st0, "busy send");
      repeat (30) tick();
      pulse_send(0);
      wait_done(0, base, "busy send");
      repeat (300) tick();
      model(0);
      cmp_stream(0, "busy send");
      chk("busy send done pulses", done_cnt[0] - base, 1);

      // Send and abort together while idle.
      base = done_cnt[0];
      st0 = starts[0];
      n = busy_cyc[0];
      got_a.delete();
      send_a = 1'b1;
      abort_a = 1'b1;
      tick();
      send_a = 1'b0;
      abort_a = 1'b0;
      repeat (300) tick();
      chk("send+abort frames", starts[0] - st0, 0);
      chk("send+abort done pulses", done_cnt[0] - base, 0);
      chk("send+abort busy cycles", busy_cyc[0] - n, 0);

      chk("read_en in frame A", re_viol[0], 0);
      chk("read_en in frame B", re_viol[1], 0);
      chk("busy dropped early A", busy_viol[0], 0);
      chk("busy dropped early B", busy_viol[1], 0);
      chk("framing errors A", ferr[0], 0);
      chk("framing errors B", ferr[1], 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
